// File: rtl/hazard_ctrl_if.sv
// hazard_ctrl_if -- signal bundle between the pipeline and the hazard unit.
//
// master : the pipeline side; drives the ID/EX hazard inputs and consumes the
//          stall/flush controls, the mult/div status and the stall counter.
// slave  : the hazard unit side (hazard_ctrl).
//
// Signals:
//   ID_rs, ID_rt        source fields of the instruction in ID
//   EX_MemRead, EX_wreg load flag and destination of the instruction in EX
//   EX_branch_taken     branch/jump in EX resolved taken
//   ID_md_start/div     ID holds mult/multu/div/divu; div selects divide
//   ID_md_read          ID holds mfhi/mflo
//   PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush   pipeline controls
//   md_busy, md_done    mult/div unit occupancy and last-busy-cycle pulse
//   md_state            current FSM state (0 = IDLE, 1 = BUSY), for debug
//   stall_cnt           saturating count of stall cycles
interface hazard_ctrl_if;
    logic [4:0]  ID_rs;
    logic [4:0]  ID_rt;
    logic        EX_MemRead;
    logic [4:0]  EX_wreg;
    logic        EX_branch_taken;
    logic        ID_md_start;
    logic        ID_md_div;
    logic        ID_md_read;
    logic        PC_stall;
    logic        IF_ID_stall;
    logic        IF_ID_flush;
    logic        ID_EX_flush;
    logic        md_busy;
    logic        md_done;
    logic        md_state;
    logic [15:0] stall_cnt;

    modport master (
        output ID_rs, ID_rt, EX_MemRead, EX_wreg, EX_branch_taken,
               ID_md_start, ID_md_div, ID_md_read,
        input  PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush,
               md_busy, md_done, md_state, stall_cnt
    );

    modport slave (
        input  ID_rs, ID_rt, EX_MemRead, EX_wreg, EX_branch_taken,
               ID_md_start, ID_md_div, ID_md_read,
        output PC_stall, IF_ID_stall, IF_ID_flush, ID_EX_flush,
               md_busy, md_done, md_state, stall_cnt
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl -- pipeline hazard unit with a multi-cycle mult/div tracker.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous, active-high reset
//   bus  hazard_ctrl_if.slave (see the interface file for the signal list)
//
// Parameters:
//   MULT_LAT  busy cycles for a multiply (2..64)
//   DIV_LAT   busy cycles for a divide   (2..64)
//
// Control semantics: a stall holds PC and IF/ID and injects a bubble into
// ID/EX; a taken branch in EX flushes IF/ID and ID/EX and always wins over a
// stall, so PC/IF_ID are never held in the same cycle as a branch flush.
// Stall and flush outputs are purely combinational from the current inputs
// and the registered FSM state, including while rst is asserted.
module hazard_ctrl #(
    parameter int MULT_LAT = 4,
    parameter int DIV_LAT  = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  bus
);
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [5:0] count;
    logic       load_use;
    logic       md_hazard;
    logic       stall;
    logic       busy;
    logic       done;

    always_comb begin
        load_use  = bus.EX_MemRead && (bus.EX_wreg != 5'd0) &&
                    ((bus.EX_wreg == bus.ID_rs) || (bus.EX_wreg == bus.ID_rt));
        busy      = (state == BUSY);
        // A new mult/div or an HI/LO read must wait while the unit is
        // occupied, including its final (md_done) cycle.
        md_hazard = busy && (bus.ID_md_read || bus.ID_md_start);
        stall     = (load_use || md_hazard) && !bus.EX_branch_taken;
        done      = busy && (count == 6'd0);
    end

    assign bus.PC_stall    = stall;
    assign bus.IF_ID_stall = stall;
    assign bus.IF_ID_flush = bus.EX_branch_taken;
    assign bus.ID_EX_flush = stall || bus.EX_branch_taken;
    assign bus.md_busy     = busy;
    assign bus.md_done     = done;
    assign bus.md_state    = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            count         <= 6'd0;
            bus.stall_cnt <= 16'd0;
        end else begin
            if (stall && (bus.stall_cnt != 16'hFFFF)) begin
                bus.stall_cnt <= bus.stall_cnt + 16'd1;
            end
            case (state)
                IDLE: begin
                    // A start squashed by a taken branch or held by a stall
                    // never reaches the unit.
                    if (bus.ID_md_start && !stall && !bus.EX_branch_taken) begin
                        state <= BUSY;
                        count <= bus.ID_md_div ? 6'(DIV_LAT - 1) : 6'(MULT_LAT - 1);
                    end
                end
                BUSY: begin
                    if (count == 6'd0) begin
                        state <= IDLE;
                    end else begin
                        count <= count - 6'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    count <= 6'd0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
module tb_hazard_ctrl;
    localparam int MULT_LAT = 4;
    localparam int DIV_LAT  = 32;

    logic clk;
    logic rst;
    hazard_ctrl_if bus ();

    hazard_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- counters ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    logic check_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_rem = busy cycles still to come (0 = unit free); m_scnt = stall count.
    int m_rem  = 0;
    int m_scnt = 0;
    // scoreboard of cycle numbers on which md_done must pulse
    logic [31:0] exp_q[$];

    function automatic logic f_stall();
        logic lu;
        logic mh;
        lu = bus.EX_MemRead && (bus.EX_wreg != 0) &&
             (bus.EX_wreg == bus.ID_rs || bus.EX_wreg == bus.ID_rt);
        mh = (m_rem > 0) && (bus.ID_md_read || bus.ID_md_start);
        return (lu || mh) && !bus.EX_branch_taken;
    endfunction

    always @(posedge clk) begin
        int lat;
        if (rst) begin
            m_rem  <= 0;
            m_scnt <= 0;
            exp_q.delete();
        end else begin
            if (f_stall()) m_scnt <= (m_scnt >= 65535) ? 65535 : m_scnt + 1;
            if (m_rem > 0) begin
                m_rem <= m_rem - 1;
            end else if (bus.ID_md_start && !bus.EX_branch_taken && !f_stall()) begin
                lat = bus.ID_md_div ? DIV_LAT : MULT_LAT;
                m_rem <= lat;
                exp_q.push_back(32'(cyc + lat));
            end
        end
        cyc <= cyc + 1;
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic s;
        logic due;
        if (check_en) begin
            s = f_stall();
            chk("pc_stall",    {31'd0, bus.PC_stall},    {31'd0, s});
            chk("if_id_stall", {31'd0, bus.IF_ID_stall}, {31'd0, s});
            chk("if_id_flush", {31'd0, bus.IF_ID_flush}, {31'd0, bus.EX_branch_taken});
            chk("id_ex_flush", {31'd0, bus.ID_EX_flush}, {31'd0, s || bus.EX_branch_taken});
            chk("md_busy",     {31'd0, bus.md_busy},     {31'd0, m_rem > 0});
            chk("stall_cnt",   {16'd0, bus.stall_cnt},   32'(m_scnt));
            due = (exp_q.size() > 0) && (exp_q[0] == 32'(cyc));
            chk("md_done",     {31'd0, bus.md_done},     {31'd0, due});
            if (due) void'(exp_q.pop_front());
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        bus.ID_rs = 5'd0; bus.ID_rt = 5'd0; bus.EX_MemRead = 1'b0; bus.EX_wreg = 5'd0;
        bus.EX_branch_taken = 1'b0; bus.ID_md_start = 1'b0; bus.ID_md_div = 1'b0;
        bus.ID_md_read = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random();
        bus.ID_rs           = 5'($urandom_range(0, 3));
        bus.ID_rt           = 5'($urandom_range(0, 3));
        bus.EX_wreg         = 5'($urandom_range(0, 3));
        bus.EX_MemRead      = ($urandom_range(0, 2) == 0);
        bus.EX_branch_taken = ($urandom_range(0, 7) == 0);
        bus.ID_md_start     = ($urandom_range(0, 5) == 0);
        bus.ID_md_div       = ($urandom_range(0, 1) == 0);
        bus.ID_md_read      = ($urandom_range(0, 4) == 0);
        rst                 = ($urandom_range(0, 299) == 0);
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n_stall;
        int saved;
        int n_done;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_en = 1'b1;
        @(negedge clk);
        chk("reset_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("reset_cnt",  {16'd0, bus.stall_cnt}, 32'd0);
        rst = 1'b0;

        // load-use on rs
        step();
        bus.EX_MemRead = 1'b1; bus.EX_wreg = 5'd5; bus.ID_rs = 5'd5;
        @(negedge clk);
        chk("lu_pc_stall", {31'd0, bus.PC_stall}, 32'd1);
        chk("lu_ifid_stall", {31'd0, bus.IF_ID_stall}, 32'd1);
        chk("lu_idex_flush", {31'd0, bus.ID_EX_flush}, 32'd1);
        step();
        clear_inputs();
        @(negedge clk);
        chk("lu_cnt", {16'd0, bus.stall_cnt}, 32'd1);

        // register 0 never creates a load-use hazard
        step();
        bus.EX_MemRead = 1'b1; bus.EX_wreg = 5'd0; bus.ID_rs = 5'd0; bus.ID_rt = 5'd0;
        @(negedge clk);
        chk("r0_no_stall", {31'd0, bus.PC_stall}, 32'd0);

        // multiply: busy for 4 cycles, done on the 4th, mfhi stalls on cycle 2
        step();
        clear_inputs();
        bus.ID_md_start = 1'b1; bus.ID_md_div = 1'b0;
        step();
        clear_inputs();
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) bus.ID_md_read = 1'b1;
            @(negedge clk);
            chk("mul_busy", {31'd0, bus.md_busy}, (k <= 4) ? 32'd1 : 32'd0);
            chk("mul_done", {31'd0, bus.md_done}, (k == 4) ? 32'd1 : 32'd0);
            if (k == 2) chk("mul_read_stall", {31'd0, bus.PC_stall}, 32'd1);
            step();
            clear_inputs();
        end

        // branch beats load-use
        bus.EX_MemRead = 1'b1; bus.EX_wreg = 5'd7; bus.ID_rt = 5'd7; bus.EX_branch_taken = 1'b1;
        @(negedge clk);
        chk("prio_pc_stall", {31'd0, bus.PC_stall}, 32'd0);
        chk("prio_ifid_stall", {31'd0, bus.IF_ID_stall}, 32'd0);
        chk("prio_ifid_flush", {31'd0, bus.IF_ID_flush}, 32'd1);
        chk("prio_idex_flush", {31'd0, bus.ID_EX_flush}, 32'd1);
        saved = m_scnt;
        step();
        clear_inputs();
        @(negedge clk);
        chk("prio_cnt_hold", {16'd0, bus.stall_cnt}, 32'(saved));

        // back-to-back divides with start held
        bus.ID_md_start = 1'b1; bus.ID_md_div = 1'b1;
        step();
        n_stall = 0;
        for (int k = 0; k < 32; k++) begin
            @(negedge clk);
            if (bus.PC_stall && bus.md_busy) n_stall++;
            step();
        end
        chk("div_stall_cycles", 32'(n_stall), 32'd32);
        @(negedge clk);
        chk("div_gap_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("div_gap_accept", {31'd0, bus.PC_stall}, 32'd0);
        step();
        clear_inputs();
        @(negedge clk);
        chk("div_second_busy", {31'd0, bus.md_busy}, 32'd1);
        repeat (34) step();

        // reset in busy cycle 10 of a divide
        bus.ID_md_start = 1'b1; bus.ID_md_div = 1'b1;
        step();
        clear_inputs();
        repeat (9) step();
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy_before", {31'd0, bus.md_busy}, 32'd1);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", {31'd0, bus.md_busy}, 32'd0);
        chk("rst_mid_done", {31'd0, bus.md_done}, 32'd0);
        chk("rst_mid_cnt", {16'd0, bus.stall_cnt}, 32'd0);
        n_done = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            @(negedge clk);
            if (bus.md_done) n_done++;
        end
        chk("rst_no_done", 32'(n_done), 32'd0);

        // saturation from a fresh count
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.EX_MemRead = 1'b1; bus.EX_wreg = 5'd9; bus.ID_rs = 5'd9;
        repeat (65540) @(posedge clk);
        #1;
        clear_inputs();
        @(negedge clk);
        chk("sat_cnt", {16'd0, bus.stall_cnt}, 32'h0000FFFF);

        // randomized traffic
        for (int k = 0; k < 3000; k++) begin
            step();
            drive_random();
        end
        step();
        clear_inputs();
        rst = 1'b0;
        repeat (70) step();
        chk("done_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
